dcache_assoc: RTL
=================

Name: dcache_assoc

Overview:
Parametrised set-associative, write-back, write-allocate data cache between the CPU load/store unit and the word-wide memory interface. It supports configurable sets, ways and line length, byte-enabled stores, dirty-line eviction and a full-cache flush command. It replaces the fixed 64-line direct-mapped data cache.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, word width; fixed at 32 because byte strobes are 4 bits
NUM_SETS, 32, number of sets; must be a power of 2, minimum 2
NUM_WAYS, 2, associativity; must be a power of 2, range 1 to 8
WORDS_PER_LINE, 4, words per line; must be a power of 2, minimum 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_addr  in  ADDR_W  byte address; bits [1:0] are ignored
cpu_read  in  1  load request
cpu_write  in  1  store request
cpu_wstrb  in  4  store byte enables
cpu_wdata  in  DATA_W  store data
cpu_flush  in  1  write back all dirty lines
cpu_rdata  out  DATA_W  load data, valid while cpu_ready is high
cpu_ready  out  1  one-cycle completion pulse
flush_done  out  1  one-cycle pulse when the flush completes
mem_addr  out  ADDR_W  word-aligned memory address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_wdata  out  DATA_W  write-back data
mem_rdata  in  DATA_W  refill data
mem_ready  in  1  memory accepted or returned the current word

Behaviour:
- Address split: OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(NUM_SETS).
  - word offset = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = the remaining upper bits
- Per-way, per-set state: valid, dirty, tag, line data. Each set also has a log2(NUM_WAYS)-bit round-robin victim pointer.
- Reset behaviour:
  - Clears all valid bits, dirty bits and victim pointers, and sends the FSM to IDLE.
  - All outputs go to 0.
  - Data and tag arrays are not cleared.
- CPU handshake:
  - The CPU holds its request and operands stable until cpu_ready.
  - cpu_read and cpu_write together is treated as a write.
  - A request is sampled only in IDLE.
- IDLE to LOOKUP: on a request, the block registers the address, data and strobes.
- LOOKUP, hit (exactly one valid way has a matching tag):
  - cpu_ready pulses the next cycle (hit latency 2 cycles from request).
  - A load returns the word.
  - A store merges bytes according to cpu_wstrb and sets dirty.
  - Return to IDLE.
- LOOKUP, miss:
  - Victim is the lowest-numbered invalid way; otherwise the set's victim pointer, which then increments modulo NUM_WAYS.
  - Go to WRITEBACK if the victim is valid and dirty, else to REFILL.
- WRITEBACK:
  - Issues WORDS_PER_LINE writes, word 0 first, to the victim's line base address.
  - mem_write, mem_addr and mem_wdata stay stable until mem_ready is sampled high; the next word is presented the following cycle.
  - After the last word, clear dirty and go to REFILL.
- REFILL:
  - Issues WORDS_PER_LINE reads from the requested line base, in ascending order, with the same handshake.
  - Each word is written to the victim way as it arrives.
  - After the last word: set valid, set tag, clear dirty, and go to LOOKUP. The request then hits.
- Flush:
  - cpu_flush in IDLE has priority over cpu_read/cpu_write.
  - FLUSH_SCAN walks set by set and way by way. Each dirty valid line is written back (FLUSH_WB) and its dirty bit cleared; lines stay valid.
  - Clean lines cost 1 scan cycle each.
  - After the last entry, pulse flush_done and return to IDLE.
  - cpu_flush outside IDLE is ignored.
- mem_read and mem_write are never high together.
- mem_ready is ignored while no memory request is pending.
- Reset mid-operation: any state returns to IDLE on the next edge, memory strobes drop, and a partially refilled line stays invalid.
- NUM_WAYS = 1: the victim pointer is absent and the block behaves as direct-mapped.

Decomposition:
- Package dcache_pkg holds:
  - the cache_state_e enum (IDLE, LOOKUP, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB)
  - address field width functions (OFF_W, IDX_W, TAG_W derived from the parameters)
  - the byte-merge function that applies the strobes
- Sub-module dcache_mem_seq: the word-sequencing counter and memory handshake shared by WRITEBACK, REFILL and FLUSH_WB. It takes start, base address and direction, and reports done.

Test Plan:
Defaults are used throughout: NUM_SETS=32, NUM_WAYS=2, WORDS_PER_LINE=4, with memory preloaded so that word at A = A + 0x1000.
1. Cold read at 0x100 -> 4 mem reads at 0x100, 0x104, 0x108, 0x10C; cpu_rdata=0x1100. Then a read at 0x108 -> hit, cpu_ready 2 cycles after the request, rdata 0x1108, no memory traffic.
2. Write to 0x100 with wstrb=0011, wdata=0xAAAABBBB (line resident, word 0x00001100) -> read returns 0x0000BBBB; zero memory transactions.
3. Same-set conflict: dirty 0x100, then reads of 0x300 and 0x500 (all index 0x10) -> on the 0x500 miss, 4 writes at 0x100..0x10C with mem_wdata[0]=0x0000BBBB, then 4 reads at 0x500..0x50C.
4. Dirty lines 0x100 and 0x204, then cpu_flush -> exactly 8 writes, one flush_done pulse. A second flush -> 0 writes, flush_done after 64 scan cycles. A subsequent read of 0x100 hits.
5. mem_ready held low for 5 cycles during a refill -> mem_read and mem_addr are stable throughout; the word is accepted on the cycle mem_ready is high.
6. rst asserted during refill word 2 -> mem_read is 0 and the FSM is in IDLE after the edge; the next read of the same address misses and issues 4 reads.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the set-associative data cache
//
// Contents:
//   cache_state_e : controller states
//   off_w/idx_w/tag_w : address field widths derived from the cache geometry
//   merge_bytes   : applies store byte strobes to a resident word
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL,
      FLUSH_SCAN,
      FLUSH_WB
   } cache_state_e;

   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int idx_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int num_sets, input int words_per_line);
      return addr_w - $clog2(num_sets) - $clog2(words_per_line) - 2;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_mem_seq.sv
// rtl/dcache_mem_seq.sv - line-burst word sequencer and memory handshake
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, base, dir    : begin a line burst at base (dir 1 = write, 0 = read)
//   line_word           : cache word for the current index (write bursts)
//   mem_ready           : memory accepted/returned the current word
//   mem_addr/read/write/wdata : memory request, held until mem_ready
//   word_idx            : index of the word currently presented
//   beat                : current word completes this cycle
//   done                : last word of the line completes this cycle
module dcache_mem_seq #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic              dir,
   input  logic [DATA_W-1:0] line_word,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [OFF_W-1:0]  word_idx,
   output logic              beat,
   output logic              done
);

   logic              active;
   logic              dir_r;
   logic [ADDR_W-1:0] base_r;
   logic [OFF_W-1:0]  cnt;

   // All request outputs derive from registers only, so they hold steady
   // for as long as the memory stalls.
   assign beat      = active & mem_ready;
   assign done      = beat & (cnt == OFF_W'(WORDS_PER_LINE - 1));
   assign word_idx  = cnt;
   assign mem_read  = active & ~dir_r;
   assign mem_write = active & dir_r;
   assign mem_addr  = active ? (base_r | ADDR_W'({cnt, 2'b00})) : '0;
   assign mem_wdata = mem_write ? line_word : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         dir_r  <= 1'b0;
         base_r <= '0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         dir_r  <= dir;
         base_r <= base;
         cnt    <= '0;
      end else if (beat) begin
         cnt <= cnt + OFF_W'(1);
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-back write-allocate data cache
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_addr/read/write/wstrb/wdata : CPU request, held until cpu_ready
//   cpu_flush                     : write back every dirty line
//   cpu_rdata, cpu_ready          : load data and one-cycle completion pulse
//   flush_done                    : one-cycle pulse at the end of a flush
//   mem_addr/read/write/wdata     : word-wide memory request
//   mem_rdata, mem_ready          : memory refill data and handshake
module dcache_assoc
   import dcache_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_SETS       = 32,
   parameter int NUM_WAYS       = 2,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [3:0]        cpu_wstrb,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              flush_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int OFF_W = off_w(WORDS_PER_LINE);
   localparam int IDX_W = idx_w(NUM_SETS);
   localparam int TAG_W = tag_w(ADDR_W, NUM_SETS, WORDS_PER_LINE);
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   localparam logic [OFF_W+1:0] LINE_ZERO = '0;

   logic [DATA_W-1:0]   data_arr  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
   logic [TAG_W-1:0]    tag_arr   [NUM_WAYS][NUM_SETS];
   logic [NUM_SETS-1:0] valid_arr [NUM_WAYS];
   logic [NUM_SETS-1:0] dirty_arr [NUM_WAYS];
   logic [WAY_W-1:0]    vptr      [NUM_SETS];

   cache_state_e      state;
   logic [TAG_W-1:0]  tag_r;
   logic [IDX_W-1:0]  idx_r;
   logic [OFF_W-1:0]  off_r;
   logic              req_write;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_wstrb;
   logic [WAY_W-1:0]  op_way;
   logic [IDX_W-1:0]  op_set;
   logic [IDX_W-1:0]  scan_set;
   logic [WAY_W-1:0]  scan_way;
   logic              seq_start;
   logic              seq_dir;
   logic [ADDR_W-1:0] seq_base;

   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  victim;
   logic              scan_last;
   logic [OFF_W-1:0]  seq_idx;
   logic              seq_beat;
   logic              seq_done;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];

   // Descending loop so the lowest-numbered matching/invalid way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_arr[w][idx_r] && (tag_arr[w][idx_r] == tag_r)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_arr[w][idx_r]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim    = inv_found ? inv_way : vptr[idx_r];
   assign scan_last = (scan_set == IDX_W'(NUM_SETS - 1)) && (scan_way == WAY_W'(NUM_WAYS - 1));

   dcache_mem_seq #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .WORDS_PER_LINE(WORDS_PER_LINE)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (seq_start),
      .base     (seq_base),
      .dir      (seq_dir),
      .line_word(data_arr[op_way][op_set][seq_idx]),
      .mem_ready(mem_ready),
      .mem_addr (mem_addr),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .mem_wdata(mem_wdata),
      .word_idx (seq_idx),
      .beat     (seq_beat),
      .done     (seq_done)
   );

   // Line data and tags carry no reset; validity alone decides whether
   // their contents are meaningful.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == REFILL && seq_beat)
            data_arr[op_way][op_set][seq_idx] <= mem_rdata;
         if (state == REFILL && seq_done)
            tag_arr[op_way][op_set] <= tag_r;
         if (state == LOOKUP && hit && req_write)
            data_arr[hit_way][idx_r][off_r] <=
               merge_bytes(data_arr[hit_way][idx_r][off_r], req_wdata, req_wstrb);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cpu_rdata  <= '0;
         cpu_ready  <= 1'b0;
         flush_done <= 1'b0;
         tag_r      <= '0;
         idx_r      <= '0;
         off_r      <= '0;
         req_write  <= 1'b0;
         req_wdata  <= '0;
         req_wstrb  <= '0;
         op_way     <= '0;
         op_set     <= '0;
         scan_set   <= '0;
         scan_way   <= '0;
         seq_start  <= 1'b0;
         seq_dir    <= 1'b0;
         seq_base   <= '0;
         for (int w = 0; w < NUM_WAYS; w++) begin
            valid_arr[w] <= '0;
            dirty_arr[w] <= '0;
         end
         for (int s = 0; s < NUM_SETS; s++) vptr[s] <= '0;
      end else begin
         cpu_ready  <= 1'b0;
         flush_done <= 1'b0;
         seq_start  <= 1'b0;
         case (state)
            IDLE: begin
               // The completion pulse cycle still sees the old request held,
               // so it must not be sampled again.
               if (!cpu_ready && !flush_done) begin
                  if (cpu_flush) begin
                     scan_set <= '0;
                     scan_way <= '0;
                     state    <= FLUSH_SCAN;
                  end else if (cpu_read || cpu_write) begin
                     tag_r     <= cpu_addr[ADDR_W-1 -: TAG_W];
                     idx_r     <= cpu_addr[OFF_W+2 +: IDX_W];
                     off_r     <= cpu_addr[2 +: OFF_W];
                     req_write <= cpu_write;
                     req_wdata <= cpu_wdata;
                     req_wstrb <= cpu_wstrb;
                     state     <= LOOKUP;
                  end
               end
            end
            LOOKUP: begin
               if (hit) begin
                  cpu_ready <= 1'b1;
                  if (req_write) dirty_arr[hit_way][idx_r] <= 1'b1;
                  else           cpu_rdata <= data_arr[hit_way][idx_r][off_r];
                  state <= IDLE;
               end else begin
                  if (!inv_found && NUM_WAYS > 1) vptr[idx_r] <= vptr[idx_r] + WAY_W'(1);
                  op_way    <= victim;
                  op_set    <= idx_r;
                  seq_start <= 1'b1;
                  if (valid_arr[victim][idx_r] && dirty_arr[victim][idx_r]) begin
                     seq_base <= {tag_arr[victim][idx_r], idx_r, LINE_ZERO};
                     seq_dir  <= 1'b1;
                     state    <= WRITEBACK;
                  end else begin
                     // Invalidate up front so a half-filled line is never seen.
                     valid_arr[victim][idx_r] <= 1'b0;
                     seq_base <= {tag_r, idx_r, LINE_ZERO};
                     seq_dir  <= 1'b0;
                     state    <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (seq_done) begin
                  dirty_arr[op_way][op_set] <= 1'b0;
                  valid_arr[op_way][op_set] <= 1'b0;
                  seq_start <= 1'b1;
                  seq_base  <= {tag_r, idx_r, LINE_ZERO};
                  seq_dir   <= 1'b0;
                  state     <= REFILL;
               end
            end
            REFILL: begin
               if (seq_done) begin
                  valid_arr[op_way][op_set] <= 1'b1;
                  dirty_arr[op_way][op_set] <= 1'b0;
                  state <= LOOKUP;
               end
            end
            FLUSH_SCAN: begin
               if (valid_arr[scan_way][scan_set] && dirty_arr[scan_way][scan_set]) begin
                  op_way    <= scan_way;
                  op_set    <= scan_set;
                  seq_start <= 1'b1;
                  seq_dir   <= 1'b1;
                  seq_base  <= {tag_arr[scan_way][scan_set], scan_set, LINE_ZERO};
                  state     <= FLUSH_WB;
               end else if (scan_last) begin
                  flush_done <= 1'b1;
                  state      <= IDLE;
               end else if (scan_way == WAY_W'(NUM_WAYS - 1)) begin
                  scan_way <= '0;
                  scan_set <= scan_set + IDX_W'(1);
               end else begin
                  scan_way <= scan_way + WAY_W'(1);
               end
            end
            FLUSH_WB: begin
               if (seq_done) begin
                  dirty_arr[op_way][op_set] <= 1'b0;
                  if (scan_last) begin
                     flush_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     state <= FLUSH_SCAN;
                     if (scan_way == WAY_W'(NUM_WAYS - 1)) begin
                        scan_way <= '0;
                        scan_set <= scan_set + IDX_W'(1);
                     end else begin
                        scan_way <= scan_way + WAY_W'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
